// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_gen_pkg;

  // Source of the redirect chosen (or latched) in a given cycle.
  typedef enum logic [2:0] {
    RD_NONE,
    RD_EXC,
    RD_BR,
    RD_JMP,
    RD_RET
  } rd_cause_e;

  localparam int unsigned DEF_PC_W      = 16;
  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_EXC_VEC   = 16'h0008;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack: circular buffer, push on full overwrites the oldest entry.
// Latency: push/pop take effect on the next rising edge; top_dat is combinational from state.
// Backpressure: none; pop on empty is dropped and flagged by a one-cycle uflow pulse.
// Ports: clk, clr_n (async active-low), push/push_dat, pop, top_dat, empty, full, uflow.
module ret_addr_stack
  import pc_gen_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_W      = DEF_PC_W
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            push,
  input  logic [PC_W-1:0] push_dat,
  input  logic            pop,
  output logic [PC_W-1:0] top_dat,
  output logic            empty,
  output logic            full,
  output logic            uflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [RAS_DEPTH-1:0][PC_W-1:0] mem_q, mem_d;
  logic [PW-1:0]                  ptr_q, ptr_d;   // next free slot
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           uflow_q, uflow_d;
  logic [PW-1:0]                  top_idx;

  assign top_idx = ptr_q - PW'(1);
  assign top_dat = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign uflow   = uflow_q;

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    uflow_d = pop && empty;
    if (push && pop && !empty) begin
      // call+ret in one cycle: the popped slot is reused for the new return address
      mem_d[top_idx] = push_dat;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else if (push) begin
      // also covers push together with an underflowing pop
      mem_d[ptr_q] = push_dat;
      ptr_d        = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: PC register, prioritised redirect mux, 1-entry pending redirect, RAS.
// Latency: redirect lands on the first rising edge with enable=1 (same edge if already enabled).
// Backpressure: enable=0 holds PC; exc/br/jmp arriving while stalled are parked in the pending slot.
// Ports: clk, clr_n, enable, exc_req, br_taken/br_target, jmp_req/jmp_target, call_push, ret_pop,
//        pc_out, redir_pend, ras_empty, ras_full, ras_uflow.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     PC_W      = DEF_PC_W,
  parameter logic [PC_W-1:0] STEP      = PC_W'(1),
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(DEF_EXC_VEC),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            enable,
  input  logic            exc_req,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_req,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [PC_W-1:0] pc_out,
  output logic            redir_pend,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_uflow
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            pend_vld_q, pend_vld_d;
  rd_cause_e       pend_cause_q, pend_cause_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  rd_cause_e       new_cause;
  logic [PC_W-1:0] new_tgt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            hard_redir;
  logic            pop_eff;
  logic            push_eff;
  logic            keep_exc;

  assign pc_inc     = pc_q + STEP;   // wraps modulo 2^PC_W
  assign hard_redir = exc_req | br_taken | jmp_req;
  // A winning exc/br/jmp squashes the return, so the RAS must not pop.
  assign pop_eff    = enable & ret_pop & ~hard_redir;
  assign push_eff   = enable & call_push;
  // A parked exception is only displaced by another exception.
  assign keep_exc   = pend_vld_q && (pend_cause_q == RD_EXC) && !exc_req;

  ret_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk      (clk),
    .clr_n    (clr_n),
    .push     (push_eff),
    .push_dat (pc_inc),
    .pop      (pop_eff),
    .top_dat  (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .uflow    (ras_uflow)
  );

  always_comb begin
    new_cause = RD_NONE;
    new_tgt   = pc_inc;
    if (exc_req) begin
      new_cause = RD_EXC;
      new_tgt   = EXC_VEC;
    end else if (br_taken) begin
      new_cause = RD_BR;
      new_tgt   = br_target;
    end else if (jmp_req) begin
      new_cause = RD_JMP;
      new_tgt   = jmp_target;
    end else if (pop_eff) begin
      new_cause = RD_RET;
      new_tgt   = ras_empty ? EXC_VEC : ras_top;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    pend_vld_d   = pend_vld_q;
    pend_cause_d = pend_cause_q;
    pend_tgt_d   = pend_tgt_q;
    if (enable) begin
      if (new_cause != RD_NONE) pc_d = new_tgt;
      else if (pend_vld_q)      pc_d = pend_tgt_q;
      else                      pc_d = pc_inc;
      pend_vld_d   = 1'b0;
      pend_cause_d = RD_NONE;
    end else if (hard_redir && !keep_exc) begin
      pend_vld_d   = 1'b1;
      pend_cause_d = new_cause;
      pend_tgt_d   = new_tgt;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q         <= RESET_VEC;
      pend_vld_q   <= 1'b0;
      pend_cause_q <= RD_NONE;
      pend_tgt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_vld_q   <= pend_vld_d;
      pend_cause_q <= pend_cause_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign pc_out     = pc_q;
  assign redir_pend = pend_vld_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        enable;
  logic        exc_req;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jmp_req;
  logic [15:0] jmp_target;
  logic        call_push;
  logic        ret_pop;
  logic [15:0] pc_out;
  logic        redir_pend;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_uflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .enable     (enable),
    .exc_req    (exc_req),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_req    (jmp_req),
    .jmp_target (jmp_target),
    .call_push  (call_push),
    .ret_pop    (ret_pop),
    .pc_out     (pc_out),
    .redir_pend (redir_pend),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_uflow  (ras_uflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; enable = 1'b0; exc_req = 1'b0; br_taken = 1'b0; br_target = '0;
    jmp_req = 1'b0; jmp_target = '0; call_push = 1'b0; ret_pop = 1'b0;
    #2;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b exp=0", redir_pend); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", ras_full); end
    checks++; if (ras_uflow !== 1'b0) begin errors++; $display("FAIL reset_uflow got=%b exp=0", ras_uflow); end
    step();
    clr_n = 1'b1;
  endtask

  task automatic test_increment();
    logic [15:0] exp_pc;
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc = 16'(i);
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL incr_%0d got=%h exp=%h", i, pc_out, exp_pc); end
    end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL async_clr got=%h exp=0000", pc_out); end
    step();
    clr_n = 1'b1; enable = 1'b0;
  endtask

  task automatic test_stall_branch();
    br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_taken = 1'b0;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL stall_hold got=%h exp=0000", pc_out); end
    checks++; if (redir_pend !== 1'b1) begin errors++; $display("FAIL stall_pend got=%b exp=1", redir_pend); end
    step();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL stall_hold2 got=%h exp=0000", pc_out); end
    enable = 1'b1;
    step();
    checks++; if (pc_out !== 16'h0040) begin errors++; $display("FAIL stall_release got=%h exp=0040", pc_out); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL stall_pend_clr got=%b exp=0", redir_pend); end
    enable = 1'b0;
  endtask

  task automatic test_priority();
    enable = 1'b1; exc_req = 1'b1; br_taken = 1'b1; br_target = 16'h0040;
    jmp_req = 1'b1; jmp_target = 16'h0080;
    step();
    exc_req = 1'b0; br_taken = 1'b0; jmp_req = 1'b0;
    checks++; if (pc_out !== 16'h0008) begin errors++; $display("FAIL prio_exc got=%h exp=0008", pc_out); end
    step();
    checks++; if (pc_out !== 16'h0009) begin errors++; $display("FAIL prio_next got=%h exp=0009", pc_out); end
    enable = 1'b0;
  endtask

  task automatic test_sticky();
    exc_req = 1'b1;
    step();
    exc_req = 1'b0; br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_taken = 1'b0;
    checks++; if (pc_out !== 16'h0009) begin errors++; $display("FAIL sticky_hold got=%h exp=0009", pc_out); end
    checks++; if (redir_pend !== 1'b1) begin errors++; $display("FAIL sticky_pend got=%b exp=1", redir_pend); end
    enable = 1'b1;
    step();
    checks++; if (pc_out !== 16'h0008) begin errors++; $display("FAIL sticky_exc got=%h exp=0008", pc_out); end
    enable = 1'b0; br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_taken = 1'b0; jmp_req = 1'b1; jmp_target = 16'h0080;
    step();
    jmp_req = 1'b0; enable = 1'b1;
    step();
    checks++; if (pc_out !== 16'h0080) begin errors++; $display("FAIL overwrite_jmp got=%h exp=0080", pc_out); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL overwrite_pend got=%b exp=0", redir_pend); end
  endtask

  task automatic test_ras();
    // enable stays 1; calls modelled as call_push together with a jump
    jmp_req = 1'b1; jmp_target = 16'h0010;
    step();
    call_push = 1'b1; jmp_target = 16'h0020;
    step();
    jmp_target = 16'h0050;
    step();
    call_push = 1'b0; jmp_req = 1'b0;
    checks++; if (pc_out !== 16'h0050) begin errors++; $display("FAIL ras_call2 got=%h exp=0050", pc_out); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL ras_nonempty got=%b exp=0", ras_empty); end
    ret_pop = 1'b1;
    step();
    checks++; if (pc_out !== 16'h0021) begin errors++; $display("FAIL ras_ret1 got=%h exp=0021", pc_out); end
    step();
    checks++; if (pc_out !== 16'h0011) begin errors++; $display("FAIL ras_ret2 got=%h exp=0011", pc_out); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ras_empty got=%b exp=1", ras_empty); end
    step();
    ret_pop = 1'b0;
    checks++; if (pc_out !== 16'h0008) begin errors++; $display("FAIL ras_uflow_pc got=%h exp=0008", pc_out); end
    checks++; if (ras_uflow !== 1'b1) begin errors++; $display("FAIL ras_uflow_pulse got=%b exp=1", ras_uflow); end
    step();
    checks++; if (ras_uflow !== 1'b0) begin errors++; $display("FAIL ras_uflow_drop got=%b exp=0", ras_uflow); end
    checks++; if (pc_out !== 16'h0009) begin errors++; $display("FAIL ras_after_uflow got=%h exp=0009", pc_out); end
  endtask

  task automatic test_ras_full();
    logic [15:0] exp_pc;
    call_push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i >= 4) begin
        checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ras_full_%0d got=%b exp=1", i, ras_full); end
      end
    end
    call_push = 1'b0; ret_pop = 1'b1;
    // pushes were 000A..000E; 000A was overwritten by the fifth push
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 16'h000E - 16'(i);
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL ras_pop_%0d got=%h exp=%h", i, pc_out, exp_pc); end
    end
    step();
    ret_pop = 1'b0;
    checks++; if (pc_out !== 16'h0008) begin errors++; $display("FAIL ras_oldest_lost got=%h exp=0008", pc_out); end
    checks++; if (ras_uflow !== 1'b1) begin errors++; $display("FAIL ras_full_uflow got=%b exp=1", ras_uflow); end
  endtask

  task automatic test_wrap_callret();
    jmp_req = 1'b1; jmp_target = 16'hFFFF;
    step();
    jmp_req = 1'b0;
    checks++; if (pc_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup got=%h exp=ffff", pc_out); end
    step();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL wrap got=%h exp=0000", pc_out); end
    jmp_req = 1'b1; jmp_target = 16'h0010;
    step();
    call_push = 1'b1; jmp_target = 16'h0030;
    step();
    jmp_req = 1'b0;
    checks++; if (pc_out !== 16'h0030) begin errors++; $display("FAIL callret_setup got=%h exp=0030", pc_out); end
    ret_pop = 1'b1;
    step();
    call_push = 1'b0;
    checks++; if (pc_out !== 16'h0011) begin errors++; $display("FAIL callret_pc got=%h exp=0011", pc_out); end
    step();
    ret_pop = 1'b0;
    checks++; if (pc_out !== 16'h0031) begin errors++; $display("FAIL callret_top got=%h exp=0031", pc_out); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL callret_count got=%b exp=1", ras_empty); end
  endtask

  task automatic test_back_to_back();
    call_push = 1'b1;
    step();
    call_push = 1'b0; ret_pop = 1'b1; jmp_req = 1'b1; jmp_target = 16'h0100;
    step();
    jmp_req = 1'b0;
    checks++; if (pc_out !== 16'h0100) begin errors++; $display("FAIL retjmp_pc got=%h exp=0100", pc_out); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL retjmp_nopop got=%b exp=0", ras_empty); end
    step();
    ret_pop = 1'b0;
    checks++; if (pc_out !== 16'h0032) begin errors++; $display("FAIL retjmp_later_ret got=%h exp=0032", pc_out); end
  endtask

  task automatic test_reset_mid_stall();
    call_push = 1'b1;
    step();
    call_push = 1'b0; enable = 1'b0; br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_taken = 1'b0;
    checks++; if (redir_pend !== 1'b1) begin errors++; $display("FAIL midstall_pend got=%b exp=1", redir_pend); end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL midstall_pc got=%h exp=0000", pc_out); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL midstall_pend_clr got=%b exp=0", redir_pend); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL midstall_ras got=%b exp=1", ras_empty); end
    step();
    clr_n = 1'b1; enable = 1'b1;
    step();
    checks++; if (pc_out !== 16'h0001) begin errors++; $display("FAIL midstall_discard got=%h exp=0001", pc_out); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_stall_branch();
    test_priority();
    test_sticky();
    test_ras();
    test_ras_full();
    test_wrap_callret();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
